// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the transmit-feed FSM state type.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, GAP, WAIT} tx_state_e;
endpackage

// File: rtl/uart_loop_fifo_if.sv
// uart_loop_fifo_if: receiver/transmitter handshake and FIFO status bundle.
interface uart_loop_fifo_if #(
  parameter int DATA_W     = uart_pkg::UART_DATA_W,
  parameter int DEPTH_LOG2 = 4
);
  logic              rx_new_data;
  logic [DATA_W-1:0] rx_data;
  logic              rx_read;
  logic              tx_busy;
  logic              tx_load;
  logic [DATA_W-1:0] tx_data;
  logic [DEPTH_LOG2:0] count;
  logic              empty;
  logic              full;
  logic              overflow;
  modport master (
    output rx_new_data, rx_data, tx_busy,
    input  rx_read, tx_load, tx_data, count, empty, full, overflow
  );
  modport slave (
    input  rx_new_data, rx_data, tx_busy,
    output rx_read, tx_load, tx_data, count, empty, full, overflow
  );
endinterface

// File: rtl/uart_loop_fifo_sync_fifo_mem.sv
// sync_fifo_mem: circular byte store with registered count/empty/full; pointers wrap modulo depth.
module sync_fifo_mem #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic empty_q, empty_d, full_q, full_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    count_d  = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    empty_d  = count_d == '0;
    full_d   = count_d == (DEPTH_LOG2+1)'(DEPTH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;
endmodule

// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: buffers received bytes and feeds them to the transmitter one at a time.
// Define UART_FIFO_DROP_EN to drop bytes when full (sticky overflow) instead of backpressuring.
module uart_loop_fifo import uart_pkg::*; #(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = 4
) (
  input logic clk,
  input logic rst,
  uart_loop_fifo_if.slave bus
);
  tx_state_e state_q, state_d;
  logic read_q, read_d, take, push, pop, overflow_q, overflow_d;
  logic [DATA_W-1:0] rdata, tx_data_q, tx_data_d;
  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(bus.rx_data), .rdata(rdata),
    .count(bus.count), .empty(bus.empty), .full(bus.full)
  );
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  always_comb begin
    pop       = !rst && state_q == IDLE && !bus.empty && !bus.tx_busy;
    take      = !rst && bus.rx_new_data && !read_q;
    push      = take && (!bus.full || pop);
    tx_data_d = pop ? rdata : tx_data_q;
    state_d   = state_q == IDLE ? (pop ? GAP : IDLE) :
                state_q == GAP  ? WAIT : (bus.tx_busy ? WAIT : IDLE);
`ifdef UART_FIFO_DROP_EN
    read_d     = take;
    overflow_d = overflow_q || (take && !push);
`else
    read_d     = push;
    overflow_d = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.rx_read  = read_d;
  assign bus.tx_load  = pop;
  assign bus.tx_data  = tx_data_d;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_loop_fifo.sv
// tb_uart_loop_fifo: scoreboard bench with receiver/transmitter models, depth 4.
module tb_uart_loop_fifo;
  localparam int DW = 8, DL = 2, DEPTH = 4;
`ifdef UART_FIFO_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, hold_busy = 0, load_seen = 0, prev_read = 0, model_ovf = 0;
  int busy_cnt = 0, n_cmp = 0, n_err = 0, model_cnt = 0, cyc = 0, last_load = -100, acks = 0, loads = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 0;
  uart_loop_fifo_if #(.DATA_W(DW), .DEPTH_LOG2(DL)) bus ();
  uart_loop_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.tx_busy = hold_busy || busy_cnt != 0;
  always @(posedge clk) busy_cnt <= rst ? 0 : load_seen ? 3 : (busy_cnt > 0 ? busy_cnt - 1 : 0);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic drop;
    cyc++;
    check("count", 32'(bus.count), model_cnt);
    check("empty", bus.empty, model_cnt == 0);
    check("full", bus.full, model_cnt == DEPTH);
    check("overflow", bus.overflow, model_ovf);
    if (rst) begin
      check("rst_read", bus.rx_read, 0);
      check("rst_load", bus.tx_load, 0);
      exp_q.delete();
      model_cnt = 0; model_ovf = 0; last_data = 0; load_seen = 0; prev_read = 0;
    end else begin
      if (bus.tx_load) begin
        check("load_busy", bus.tx_busy, 0);
        check("load_gap", cyc - last_load >= 3, 1);
        check("load_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("tx_data", bus.tx_data, exp_q.pop_front());
        last_load = cyc; last_data = bus.tx_data; loads++;
      end else check("tx_hold", bus.tx_data, last_data);
      check("read_holdoff", bus.rx_read && prev_read, 0);
      check("read_no_data", bus.rx_read && !bus.rx_new_data, 0);
      check("ack_when_full", bus.rx_read && model_cnt == DEPTH && !bus.tx_load && !DROP_EN, 0);
      drop = bus.rx_read && model_cnt == DEPTH && !bus.tx_load;
      if (bus.rx_read) begin
        acks++;
        if (drop) model_ovf = 1; else exp_q.push_back(bus.rx_data);
      end
      model_cnt += (bus.rx_read && !drop ? 1 : 0) - (bus.tx_load ? 1 : 0);
      prev_read = bus.rx_read;
      load_seen = bus.tx_load;
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_new_data = 1; bus.rx_data = b;
  endtask
  task automatic try_ack(int n, output bit got);
    got = 0;
    for (int i = 0; i < n && !got; i++) begin
      @(negedge clk);
      got = bus.rx_read;
    end
    @(posedge clk); #1;
    if (got) bus.rx_new_data = 0;
  endtask
  task automatic await_ack(string tag);
    bit got;
    try_ack(200, got);
    check(tag, got, 1);
    bus.rx_new_data = 0;
  endtask
  task automatic send(logic [7:0] b);
    drive(b);
    await_ack("ack");
  endtask
  task automatic drain(string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && model_cnt == 0 && busy_cnt == 0) break;
    end
    check(tag, exp_q.size(), 0);
    cycles(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, a0;
    bit got;
    bus.rx_new_data = 1; bus.rx_data = 8'h41;
    cycles(3);
    rst = 0;
    await_ack("t1_ack");
    drain("t1_drain");
    check("t1_acks", acks, 1);
    check("t1_loads", loads, 1);

    hold_busy = 1; l0 = loads;
    for (int i = 0; i < 3; i++) send(8'h10 + 8'(i));
    cycles(2);
    check("t2_count", 32'(bus.count), 3);
    check("t2_noload", loads, l0);
    hold_busy = 0;
    drain("t2_drain");
    check("t2_loads", loads - l0, 3);

    hold_busy = 1; l0 = loads;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    cycles(1);
    check("t3_full", bus.full, 1);
    a0 = acks;
    drive(8'h24);
    try_ack(5, got);
    check("t3_ack_early", got, DROP_EN);
    check("t3_acks", acks - a0, DROP_EN);
    check("t3_ovf", bus.overflow, DROP_EN);
    hold_busy = 0;
    if (!got) await_ack("t3_ack_late");
    drain("t3_drain");
    check("t3_loads", loads - l0, DROP_EN ? 4 : 5);
    check("t3_ovf_sticky", bus.overflow, DROP_EN);

    hold_busy = 1; l0 = loads;
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
    cycles(2);
    hold_busy = 0; bus.rx_new_data = 1; bus.rx_data = 8'h34;
    @(negedge clk);
    check("t5_pop", bus.tx_load, 1);
    check("t5_push", bus.rx_read, 1);
    @(posedge clk); #1;
    bus.rx_new_data = 0;
    @(negedge clk);
    check("t5_count", 32'(bus.count), 4);
    for (int i = 0; i < 40; i++) send(8'h50 + 8'(i));
    drain("t5_drain");
    check("t5_loads", loads - l0, 45);

    hold_busy = 1;
    for (int i = 0; i < 4; i++) send(8'h60 + 8'(i));
    cycles(1);
    hold_busy = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.tx_load;
    end
    check("t6_load", got, 1);
    @(posedge clk); #1;
    hold_busy = 1;
    cycles(2);
    check("t6_count", 32'(bus.count), 3);
    rst = 1;
    cycles(2);
    rst = 0; hold_busy = 0; l0 = loads;
    cycles(10);
    check("t6_noload", loads, l0);
    check("t6_empty", bus.empty, 1);
    check("t6_count0", 32'(bus.count), 0);
    send(8'h77);
    drain("t6_drain");
    check("t6_loads", loads - l0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
